// File: rtl/clk_pkg.sv
// Shared display constants and the scan FSM state type used by the
// display path (seg_scan, seg_decode) and the clock/mode logic.
package clk_pkg;

  localparam logic [10:0] NUM_BLANK = 11'd10;
  localparam logic [10:0] NUM_DASH  = 11'd11;

  // Active-low patterns, bit 0 = segment a .. bit 6 = g, bit 7 = dp (kept off)
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic {BLANK, SHOW} scan_state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational digit-code to active-low 7-segment pattern decoder.
module seg_decode
  import clk_pkg::*;
(
  input  logic [10:0] code,
  output logic [7:0]  pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      11'd0:    pattern = SEG_0;
      11'd1:    pattern = SEG_1;
      11'd2:    pattern = SEG_2;
      11'd3:    pattern = SEG_3;
      11'd4:    pattern = SEG_4;
      11'd5:    pattern = SEG_5;
      11'd6:    pattern = SEG_6;
      11'd7:    pattern = SEG_7;
      11'd8:    pattern = SEG_8;
      11'd9:    pattern = SEG_9;
      NUM_DASH: pattern = SEG_DASH;
      default:  pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit common-anode 7-segment scanner with a per-slot
// ghosting blank interval and frame-based blinking of masked digits.
module seg_scan
  import clk_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 62
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] num,
  input  logic        blink_en,
  input  logic [7:0]  blink_mask,
  output logic [2:0]  light,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  scan_state_t   state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic [7:0]    dec;

  seg_decode u_decode (
    .code    (num),
    .pattern (dec)
  );

  assign frame_tick = (cnt == CNT_LAST) && (light == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      cnt         <= '0;
      light       <= 3'd0;
      an          <= 8'hFF;
      seg         <= 8'hFF;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      // blink timebase advances once per full 8-digit frame, independent of blink_en
      if (frame_tick) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      case (state)
        BLANK: begin
          cnt <= cnt + 1'b1;
          if (cnt == BLANK_LAST) begin
            state <= SHOW;
            seg   <= dec;
            if (blink_en && blink_mask[light] && blink_phase)
              an <= 8'hFF;
            else
              an <= ~(8'b1 << light);
          end
        end
        SHOW: begin
          // seg is left alone at slot end; anodes are already off
          if (cnt == CNT_LAST) begin
            state <= BLANK;
            cnt   <= '0;
            an    <= 8'hFF;
            light <= light + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
          an    <= 8'hFF;
        end
      endcase
    end
  end

endmodule
